// File: rtl/serial_addsub_fsm.sv
// Bit-serial adder/subtractor with a start/clear FSM.
// Operands stream in LSB-first, one bit per clock, for WIDTH bits. The block
// emits a registered serial sum bit each cycle and presents the parallel sum,
// final carry/borrow and two's-complement overflow in a one-cycle DONE state.
// Subtraction is A + ~B + ~CIN, so in sub mode COUT=1 means "no borrow".
// Optional feature macro: SERIAL_STALL_EN adds a bit_en input that lets the
// source hold off a bit while in RUN (carry, count and sum freeze).
module serial_addsub_fsm #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             clr,
  input  logic             sub,
  input  logic             CIN,
  input  logic             A,
  input  logic             B,
`ifdef SERIAL_STALL_EN
  input  logic             bit_en,
`endif
  output logic             S,
  output logic             S_valid,
  output logic             COUT,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               mode;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               step_en;
  logic               consume;
  logic               last_bit;
  logic               start_ok;
  logic               b_eff;
  logic               s_bit;
  logic               c_next;

  // One full-adder bit: sum output.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // One full-adder bit: carry output (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef SERIAL_STALL_EN
  assign step_en = bit_en;
`else
  assign step_en = 1'b1;
`endif

  // A bit is consumed only on RUN edges the source has not stalled.
  assign consume  = (state_q == RUN) && step_en;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  // B is inverted in sub mode; the carry was pre-loaded with ~CIN for sub.
  assign b_eff  = B ^ mode;
  assign s_bit  = fa_sum(A, b_eff, carry);
  assign c_next = fa_carry(A, b_eff, carry);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Next-state logic; clr is handled in the register process with top priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (consume && last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus serial datapath; RST and clr both return everything to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mode    <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      S       <= 1'b0;
      S_valid <= 1'b0;
      COUT    <= 1'b0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      mode    <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      S       <= 1'b0;
      S_valid <= 1'b0;
      COUT    <= 1'b0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      S_valid <= consume;
      if (start_ok) begin
        mode  <= sub;
        carry <= CIN ^ sub;
        cnt   <= '0;
      end else if (consume) begin
        S     <= s_bit;
        carry <= c_next;
        cnt   <= cnt + CNT_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt == CNT_W'(i)) sum[i] <= s_bit;
        end
        // On the MSB, carry holds the carry into the MSB and c_next the carry out.
        if (last_bit) begin
          COUT <= c_next;
          ovf  <= carry ^ c_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// Directed testbench for serial_addsub_fsm (WIDTH=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Expected values are hand-computed constants.
module tb_serial_addsub_fsm;

  localparam int W = 8;

  logic         CLK    = 1'b0;
  logic         RST    = 1'b1;
  logic         start  = 1'b0;
  logic         clr    = 1'b0;
  logic         sub    = 1'b0;
  logic         CIN    = 1'b0;
  logic         A      = 1'b0;
  logic         B      = 1'b0;
  logic         bit_en = 1'b1;
  logic         S;
  logic         S_valid;
  logic         COUT;
  logic [W-1:0] sum;
  logic         ovf;
  logic         busy;
  logic         done;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int done_cyc  = 0;

  serial_addsub_fsm #(.WIDTH(W), .CNT_W(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .clr     (clr),
    .sub     (sub),
    .CIN     (CIN),
    .A       (A),
    .B       (B),
`ifdef SERIAL_STALL_EN
    .bit_en  (bit_en),
`endif
    .S       (S),
    .S_valid (S_valid),
    .COUT    (COUT),
    .sum     (sum),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Issue start for one edge. in_done=1 means we are already inside the DONE
  // cycle (just after its rising edge) and start is raised there.
  task automatic begin_op(input logic s, input logic c, input bit in_done);
    if (!in_done) @(negedge CLK);
    start = 1'b1;
    sub   = s;
    CIN   = c;
    @(posedge CLK);
    #1;
    start_cyc = cyc;
    @(negedge CLK);
    start = 1'b0;
    sub   = ~s;
    CIN   = ~c;
  endtask

  // Stream WIDTH bits and check the serial stream and the DONE result.
  // pulse_at: bit index during which start is pulsed (-1 none).
  // stall_at: bit index before which bit_en is held low for 2 edges (-1 none).
  task automatic run_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input int pulse_at, input int stall_at, input string nm);
    int stalls;
    stalls = 0;
    for (int i = 0; i < W; i++) begin
      if (i != 0) @(negedge CLK);
      if (i == stall_at) begin
        bit_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
          A = ~a[i];
          B = ~b[i];
          @(posedge CLK);
          #1;
          checks++;
          if (S_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s stall%0d: S_valid=%b busy=%b done=%b required 0 1 0",
                     nm, k, S_valid, busy, done);
          end
          @(negedge CLK);
        end
        bit_en = 1'b1;
        stalls = 2;
      end
      start = (i == pulse_at);
      A = a[i];
      B = b[i];
      @(posedge CLK);
      #1;
      checks++;
      if (S !== es[i] || S_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s bit%0d: S=%b S_valid=%b required S=%b S_valid=1",
                 nm, i, S, S_valid, es[i]);
      end
      if (i < W - 1) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s early bit%0d: done=%b busy=%b required 0 1", nm, i, done, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b required 1 0", nm, done, busy);
    end
    checks++;
    if (sum !== es || COUT !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL %s result: sum=%h COUT=%b ovf=%b required sum=%h COUT=%b ovf=%b",
               nm, sum, COUT, ovf, es, ec, eo);
    end
    checks++;
    if (cyc - start_cyc !== W + stalls) begin
      errors++;
      $display("FAIL %s latency: %0d edges required %0d", nm, cyc - start_cyc, W + stalls);
    end
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (S !== 1'b0 || S_valid !== 1'b0 || COUT !== 1'b0 || sum !== '0 ||
        ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: S=%b S_valid=%b COUT=%b sum=%h ovf=%b busy=%b done=%b required all 0",
               S, S_valid, COUT, sum, ovf, busy, done);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_add();
    begin_op(1'b0, 1'b0, 1'b0);
    run_bits(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, -1, -1, "add");
    // After DONE the block idles: no done/S_valid, results hold.
    repeat (3) begin
      @(posedge CLK);
      #1;
      checks++;
      if (done !== 1'b0 || S_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
        errors++;
        $display("FAIL idle_hold: done=%b S_valid=%b busy=%b sum=%h required 0 0 0 96",
                 done, S_valid, busy, sum);
      end
    end
  endtask

  task automatic test_add_wrap();
    begin_op(1'b0, 1'b0, 1'b0);
    run_bits(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, -1, -1, "add_wrap");
  endtask

  task automatic test_clr();
    begin_op(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge CLK);
      A = 1'b1;
      B = 1'b0;
      @(posedge CLK);
    end
    @(negedge CLK);
    clr = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== '0 || COUT !== 1'b0 || done !== 1'b0 || S_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr: busy=%b sum=%h COUT=%b done=%b S_valid=%b required all 0",
               busy, sum, COUT, done, S_valid);
    end
    @(negedge CLK);
    clr = 1'b0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_after: done=%b busy=%b required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_sub();
    begin_op(1'b1, 1'b0, 1'b0);
    run_bits(8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, -1, -1, "sub_borrow");
    begin_op(1'b1, 1'b1, 1'b0);
    run_bits(8'h10, 8'h0F, 8'h00, 1'b1, 1'b0, -1, -1, "sub_bin");
  endtask

  task automatic test_async_rst();
    begin_op(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge CLK);
      A = 1'b1;
      B = 1'b0;
      @(posedge CLK);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== '0 || COUT !== 1'b0 || S !== 1'b0 ||
        S_valid !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: busy=%b sum=%h COUT=%b S=%b S_valid=%b done=%b ovf=%b required all 0",
               busy, sum, COUT, S, S_valid, done, ovf);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first_done;
    begin_op(1'b0, 1'b0, 1'b0);
    run_bits(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, -1, -1, "b2b_first");
    first_done = done_cyc;
    // Still inside DONE: hold start for the next operation. A start pulse
    // during the second RUN (with sub=1) must be ignored.
    begin_op(1'b0, 1'b0, 1'b1);
    run_bits(8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 3, -1, "b2b_second");
    checks++;
    if (done_cyc - first_done !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: %0d cycles required 9", done_cyc - first_done);
    end
  endtask

`ifdef SERIAL_STALL_EN
  task automatic test_stall();
    begin_op(1'b0, 1'b0, 1'b0);
    run_bits(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, -1, 4, "stall");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_clr();
    test_sub();
    test_async_rst();
    test_back_to_back();
`ifdef SERIAL_STALL_EN
    test_stall();
`endif
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_fsm.md
Name: serial_addsub_fsm

Overview:
Parametrised bit-serial adder/subtractor controlled by a start/clear FSM. This is the next generation of the team's single-bit serial full-adder state machine.
- Operands A and B are streamed in LSB-first, one bit per clock, for WIDTH bits.
- A per-bit serial sum stream is produced.
- At the end of an operation the block presents the parallel sum, final carry/borrow and signed overflow.
- It sits between serial operand sources and a word-level consumer.

Parameters:
WIDTH, 8, operand/result length in bits (>=2).
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  asynchronous, active-high reset.
start  input  1  begin an operation; sampled in IDLE or DONE.
clr  input  1  synchronous soft clear, active-high.
sub  input  1  mode, sampled with start: 0 = A+B+CIN, 1 = A-B-CIN.
CIN  input  1  carry-in (add) or borrow-in (sub), sampled with start.
A  input  1  serial operand A bit, LSB-first.
B  input  1  serial operand B bit, LSB-first.
S  output  1  registered serial sum bit.
S_valid  output  1  S carries a valid bit this cycle.
COUT  output  1  final carry-out; in sub mode 1 = no borrow.
sum  output  WIDTH  parallel result.
ovf  output  1  two's-complement overflow of the result.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse; result valid.

Behaviour:
- RST=1 (async): state=IDLE. S, S_valid, COUT, sum, ovf, busy and done all 0; carry and count cleared.
- clr=1 at an edge (RST low) has priority over start and over all state activity. Next cycle: same values as RST.
- Internal B' = B ^ mode. Carry register is initialised to CIN ^ sub, so sub computes A + ~B + ~CIN.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN. Latch mode, carry=CIN^sub, count=0.
- RUN, each edge:
  - S <= A^B'^carry; carry <= majority(A,B',carry).
  - sum[count] <= S value; S_valid <= 1; count++.
  - Capture the carry into the MSB when count==WIDTH-1.
  - On the edge consuming bit WIDTH-1 -> DONE.
  - start is ignored in RUN.
- Timing: start sampled at edge k; bit i sampled at edge k+1+i, i = 0..WIDTH-1. S/S_valid for bit i are visible after edge k+1+i.
- DONE, one cycle:
  - done=1, busy=0, S_valid=1 (last bit).
  - COUT = final carry; ovf = carry into MSB ^ final carry; sum complete.
  - Next state: start=1 -> RUN (back-to-back, new operands latched), else IDLE.
- In IDLE, S_valid=0 and done=0. sum, COUT and ovf hold their last values until the next start, clr or RST.
- sum bits not yet written in the current operation retain their old values. Consumers use sum only when done=1.
- RST asserted mid-operation aborts immediately. No partial result is retained.

Optional Feature:
SERIAL_STALL_EN
- Defined: adds input port bit_en (1 bit). In RUN, an edge with bit_en=0 consumes no bit: carry, count and sum hold, S_valid=0. bit_en is ignored outside RUN.
- Undefined: port absent; every RUN cycle consumes one bit; behaviour exactly as above.

Test Plan:
- Add, WIDTH=8, A=0x5A, B=0x3C, CIN=0, sub=0 -> done after 8 bit cycles. sum=0x96, COUT=0, ovf=1; S stream LSB-first 0,1,1,0,1,0,0,1.
- Add wrap, A=0xFF, B=0x01, CIN=0 -> sum=0x00, COUT=1, ovf=0.
- Sub, A=0x10, B=0x20, CIN=0, sub=1 -> sum=0xF0, COUT=0 (borrow), ovf=0. Sub with borrow-in, A=0x10, B=0x0F, CIN=1 -> sum=0x00, COUT=1.
- Back-to-back: start held in the DONE cycle with A=0x01, B=0x01 -> second done exactly 9 cycles after the first, sum=0x02. start pulsed during RUN -> no effect.
- clr after 3 bits of an add -> next cycle IDLE, busy=0, sum=0, COUT=0, no done pulse. Async RST mid-RUN -> outputs 0 before the next clock edge.
- With SERIAL_STALL_EN: A=0x5A, B=0x3C, bit_en low for 2 cycles mid-stream -> done 2 cycles later, sum=0x96, S_valid low during the stalls.
